// File: rtl/sample_iterator.sv
// sample_iterator: walks every sample position of a triangle's bounding box, row-major, ll to ur.
// Latency: first sample one cycle after acceptance, then one sample per cycle. Optional macro DOWNSTREAM_HALT_EN.
// Backpressure: halt_RnnnnH stalls upstream while iterating; with DOWNSTREAM_HALT_EN, halt_R14H freezes everything.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                   validTri_R13H,
    input  logic [3:0]                             subSample_RnnnnU,
`ifdef DOWNSTREAM_HALT_EN
    input  logic                                   halt_R14H,
`endif
    output logic                                   halt_RnnnnH,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                   validSamp_R14H
);

    typedef enum logic {WAIT, TEST} state_t;

    localparam logic [SIGFIG:0] ONE_PX = {{SIGFIG{1'b0}}, 1'b1} << RADIX;

    state_t                                 state_q;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q;
    logic [1:0][SIGFIG-1:0]                 sample_q;
    logic [1:0][SIGFIG-1:0]                 ll_q;
    logic [1:0][SIGFIG-1:0]                 ur_q;
    logic [SIGFIG:0]                        step_q;
    logic [SIGFIG:0]                        step_d;
    logic                                   valid_q;

    logic signed [SIGFIG:0] next_x_d;
    logic signed [SIGFIG:0] next_y_d;
    logic                   x_fits;
    logic                   y_fits;
    logic                   box_inv;
    logic                   freeze;

`ifdef DOWNSTREAM_HALT_EN
    assign freeze      = halt_R14H;
    assign halt_RnnnnH = (state_q == TEST) | halt_R14H;
`else
    assign freeze      = 1'b0;
    assign halt_RnnnnH = (state_q == TEST);
`endif

    always_comb begin
        step_d = ONE_PX;
        case (subSample_RnnnnU)
            4'b1000: step_d = ONE_PX;
            4'b0100: step_d = ONE_PX >> 1;
            4'b0010: step_d = ONE_PX >> 2;
            4'b0001: step_d = ONE_PX >> 3;
            default: step_d = ONE_PX;
        endcase
    end

    // One extra bit of headroom so a step past the positive limit compares as larger, not wrapped.
    assign next_x_d = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed(step_q);
    assign next_y_d = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed(step_q);
    assign x_fits   = next_x_d <= $signed({ur_q[0][SIGFIG-1], ur_q[0]});
    assign y_fits   = next_y_d <= $signed({ur_q[1][SIGFIG-1], ur_q[1]});

    assign box_inv  = ($signed(box_R13S[1][0]) < $signed(box_R13S[0][0])) ||
                      ($signed(box_R13S[1][1]) < $signed(box_R13S[0][1]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT;
            tri_q    <= '0;
            color_q  <= '0;
            sample_q <= '0;
            ll_q     <= '0;
            ur_q     <= '0;
            step_q   <= '0;
            valid_q  <= 1'b0;
        end else if (!freeze) begin
            case (state_q)
                WAIT: begin
                    if (validTri_R13H) begin
                        tri_q    <= tri_R13S;
                        color_q  <= color_R13U;
                        step_q   <= step_d;
                        ll_q     <= box_R13S[0];
                        // An inverted box collapses to ll so exactly one sample is emitted.
                        ur_q     <= box_inv ? box_R13S[0] : box_R13S[1];
                        sample_q <= box_R13S[0];
                        valid_q  <= 1'b1;
                        state_q  <= TEST;
                    end else begin
                        valid_q  <= 1'b0;
                    end
                end
                TEST: begin
                    if (x_fits) begin
                        sample_q[0] <= next_x_d[SIGFIG-1:0];
                    end else if (y_fits) begin
                        sample_q[0] <= ll_q[0];
                        sample_q[1] <= next_y_d[SIGFIG-1:0];
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= WAIT;
                end
            endcase
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Randomized and directed bench for sample_iterator with a queue-based scoreboard.
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int MAXP   = 8388607;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [2:0][2:0][SIGFIG-1:0]    tri_in = '0;
    logic [2:0][SIGFIG-1:0]         col_in = '0;
    logic [1:0][1:0][SIGFIG-1:0]    box_in = '0;
    logic                           vtri = 1'b0;
    logic [3:0]                     ss_in = 4'b1000;
    logic                           dhalt = 1'b0;

    logic                           halt_RnnnnH;
    logic [2:0][2:0][SIGFIG-1:0]    tri_R14S;
    logic [2:0][SIGFIG-1:0]         color_R14U;
    logic [1:0][SIGFIG-1:0]         sample_R14S;
    logic                           validSamp_R14H;

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (col_in),
        .box_R13S         (box_in),
        .validTri_R13H    (vtri),
        .subSample_RnnnnU (ss_in),
`ifdef DOWNSTREAM_HALT_EN
        .halt_R14H        (dhalt),
`endif
        .halt_RnnnnH      (halt_RnnnnH),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                          x;
        int                          y;
        logic [2:0][2:0][SIGFIG-1:0] tv;
        logic [2:0][SIGFIG-1:0]      cv;
        bit                          last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   gap_pending = 1'b0;

    function automatic int step_of(input logic [3:0] ss);
        case (ss)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int x, input int y, input bit last);
        exp_t e;
        e.x = x; e.y = y; e.tv = tri_in; e.cv = col_in; e.last = last;
        q.push_back(e);
    endtask

    // Reference: enumerate the sample grid directly from the box and step.
    task automatic load_tri(input int llx, input int lly, input int urx, input int ury,
                            input logic [3:0] ss);
        int st, nx, ny;
        for (int v = 0; v < 3; v++) begin
            col_in[v] = SIGFIG'($urandom);
            for (int a = 0; a < 3; a++) tri_in[v][a] = SIGFIG'($urandom);
        end
        box_in[0][0] = SIGFIG'(llx); box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx); box_in[1][1] = SIGFIG'(ury);
        ss_in = ss;
        st = step_of(ss);
        if (urx < llx || ury < lly) begin
            push_exp(llx, lly, 1'b1);
        end else begin
            nx = (urx - llx) / st + 1;
            ny = (ury - lly) / st + 1;
            for (int j = 0; j < ny; j++)
                for (int i = 0; i < nx; i++)
                    push_exp(llx + i * st, lly + j * st, (i == nx - 1) && (j == ny - 1));
        end
    endtask

    task automatic send();
        vtri = 1'b1;
        @(posedge clk); #1;
        vtri = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (halt_RnnnnH && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL wait_idle timeout actual=busy expected=idle");
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"},  longint'(validSamp_R14H), 0);
        chk({nm, "_halt"},   longint'(halt_RnnnnH), 0);
        chk({nm, "_sample"}, longint'(sample_R14S != '0), 0);
        chk({nm, "_tri"},    longint'(tri_R14S != '0), 0);
        chk({nm, "_color"},  longint'(color_R14U != '0), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (halt_RnnnnH !== (validSamp_R14H | dhalt)) begin
            errors++;
            $display("FAIL halt actual=%0b expected=%0b", halt_RnnnnH, validSamp_R14H | dhalt);
        end
        if (gap_pending) begin
            checks++;
            gap_pending = 1'b0;
            if (validSamp_R14H) begin
                errors++;
                $display("FAIL gap actual=valid expected=idle_cycle");
            end
        end else if (validSamp_R14H) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL extra_sample actual=(%0d,%0d) expected=none",
                         $signed(sample_R14S[0]), $signed(sample_R14S[1]));
            end else begin
                e = q[0];
                if ($signed(sample_R14S[0]) != e.x || $signed(sample_R14S[1]) != e.y ||
                    tri_R14S != e.tv || color_R14U != e.cv) begin
                    errors++;
                    $display("FAIL sample actual=(%0d,%0d) expected=(%0d,%0d) tri_ok=%0b col_ok=%0b",
                             $signed(sample_R14S[0]), $signed(sample_R14S[1]), e.x, e.y,
                             tri_R14S == e.tv, color_R14U == e.cv);
                end
                if (!dhalt) begin
                    void'(q.pop_front());
                    gap_pending = e.last;
                end
            end
        end
    end

    initial begin
        int st, llx, lly, urx, ury, r;
        logic [3:0] ss;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        load_tri(0, 0, 2048, 1024, 4'b1000);      send(); wait_idle();
        load_tri(512, 512, 1024, 1024, 4'b0100);  send(); wait_idle();
        load_tri(3072, 2048, 3072, 2048, 4'b0010); send(); wait_idle();
        load_tri(MAXP - 1024, MAXP - 1024, MAXP, MAXP, 4'b1000); send(); wait_idle();
        load_tri(4096, 100, 1024, 5000, 4'b0001); send(); wait_idle();
        load_tri(-3000, -2000, -1000, -1000, 4'b0110); send(); wait_idle();

        // validTri held across two triangles
        load_tri(0, 0, 1024, 0, 4'b1000);
        vtri = 1'b1;
        @(posedge clk); #1;
        load_tri(2048, 2048, 3072, 3072, 4'b0100);
        wait_idle();
        @(posedge clk); #1;
        vtri = 1'b0;
        wait_idle();

        // reset on the third sample drops the rest of the triangle
        load_tri(0, 0, 2048, 1024, 4'b1000);
        send();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_x", longint'($signed(sample_R14S[0])), 2048);
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        gap_pending = 1'b0;
        chk_zero("rst_mid");
        rst = 1'b0;
        load_tri(1024, 1024, 2048, 2048, 4'b1000);
        send();
        chk("restart_x", longint'($signed(sample_R14S[0])), 1024);
        chk("restart_y", longint'($signed(sample_R14S[1])), 1024);
        wait_idle();

`ifdef DOWNSTREAM_HALT_EN
        load_tri(0, 0, 2048, 1024, 4'b1000);
        send();
        @(posedge clk); #1;
        dhalt = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("freeze_x", longint'($signed(sample_R14S[0])), 1024);
        end
        dhalt = 1'b0;
        @(posedge clk); #1;
        chk("unfreeze_x", longint'($signed(sample_R14S[0])), 2048);
        wait_idle();
`endif

        repeat (25) begin
            r  = $urandom_range(0, 4);
            ss = (r < 4) ? (4'b1000 >> r) : 4'($urandom);
            st = step_of(ss);
            llx = int'($urandom_range(0, 8192)) - 4096;
            lly = int'($urandom_range(0, 8192)) - 4096;
            urx = llx + int'($urandom_range(0, 4)) * st + int'($urandom_range(0, st - 1));
            ury = lly + int'($urandom_range(0, 4)) * st + int'($urandom_range(0, st - 1));
            if ($urandom_range(0, 7) == 0) urx = llx - 1 - int'($urandom_range(0, 2000));
            if ($urandom_range(0, 7) == 0) ury = lly - 1 - int'($urandom_range(0, 2000));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            load_tri(llx, lly, urx, ury, ss);
            send();
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("drain", longint'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Raster-stage block that walks every sample position inside a triangle's bounding box, in row-major order.
- Sits directly upstream of the sample test stage. Each cycle it feeds that stage one candidate sample, plus the held triangle and its color.
- Stalls the bounding-box stage with a halt flag while a triangle is being iterated.

Parameters:
SIGFIG, 24, bits in color and position (signed fixed point)
RADIX, 10, fraction bits; 1.0 pixel = 1<<RADIX
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
tri_R13S  in  signed SIGFIG x VERTS x AXIS  triangle from bounding-box stage
color_R13U  in  unsigned SIGFIG x COLORS  triangle color
box_R13S  in  signed SIGFIG x 2 x 2  [0]=lower-left (x,y), [1]=upper-right (x,y), sample-aligned
validTri_R13H  in  1  triangle and box valid
subSample_RnnnnU  in  4  one-hot sample rate: 1000=1/px, 0100=2/px, 0010=4/px, 0001=8/px per axis
halt_RnnnnH  out  1  high = iterator busy; upstream must hold its inputs
tri_R14S  out  signed SIGFIG x VERTS x AXIS  held triangle
color_R14U  out  unsigned SIGFIG x COLORS  held color
sample_R14S  out  signed SIGFIG x 2  current sample (x,y)
validSamp_R14H  out  1  sample_R14S is a valid sample of the held triangle

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: state=WAIT; all R14 outputs 0; validSamp_R14H=0; halt_RnnnnH=0.
- step = (1<<RADIX) >> k, where k = 0,1,2,3 for subSample 1000,0100,0010,0001.
- Non-one-hot subSample: step is the 1/px value.
- subSample is sampled only on triangle acceptance and held for the whole triangle.
- FSM has two states, WAIT and TEST.
- WAIT:
  - halt_RnnnnH=0.
  - If validTri_R13H=1: latch tri, color and box; set sample_R14S=box ll; set validSamp_R14H=1; go to TEST.
  - Latency from accept to first sample is 1 cycle.
  - Otherwise validSamp_R14H=0.
- TEST:
  - halt_RnnnnH=1, driven combinationally from state==TEST.
  - Advance once per cycle:
    - If x+step <= ur.x: x += step.
    - Else if y+step <= ur.y: x = ll.x, y += step.
    - Else: last sample has been emitted; validSamp_R14H=0; go to WAIT.
  - The cycle that returns to WAIT emits no sample.
  - validTri_R13H is ignored while in TEST.
- Sample count per triangle: N = (floor((ur.x-ll.x)/step)+1) * (floor((ur.y-ll.y)/step)+1).
- The block spends N cycles in TEST, then at least 1 cycle in WAIT between triangles.
- Next-position arithmetic is done at SIGFIG+1 bits so x+step cannot wrap near the positive limit.
- Degenerate box ll==ur: exactly one sample.
- Box with ur<ll on either axis: exactly one sample at ll; the downstream test rejects it.
- Reset asserted mid-triangle: next cycle is WAIT with all outputs 0; the partial triangle is dropped.
- tri_R14S and color_R14U stay constant for every sample of a triangle.
- sample_R14S holds its last value while in WAIT.

Optional Feature:
Macro DOWNSTREAM_HALT_EN.
- When defined:
  - Adds input halt_R14H (1 bit).
  - While halt_R14H=1, all state, sample and output registers freeze, including the WAIT→TEST acceptance.
  - halt_RnnnnH = (state==TEST) | halt_R14H.
  - A sample presented during a freeze stays on sample_R14S and is not repeated or skipped.
- When not defined: no such port; behaviour as above.

Test Plan:
1. RADIX=10, subSample=1000, box ll=(0,0) ur=(2048,1024), validTri pulse -> validSamp high 6 consecutive cycles with (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024); halt high for those 6 cycles; then WAIT.
2. subSample=0100, box ll=(512,512) ur=(1024,1024) -> 4 samples: (512,512),(1024,512),(512,1024),(1024,1024).
3. Box ll==ur=(3072,2048) -> exactly one valid cycle at (3072,2048); halt high 1 cycle.
4. validTri held high continuously across two triangles -> second triangle is accepted only in the WAIT cycle after the first finishes; one-cycle validSamp gap; no sample lost or duplicated.
5. rst asserted on sample 3 of test 1 -> next cycle validSamp=0, halt=0, outputs 0; a new triangle restarts at its ll.
6. DOWNSTREAM_HALT_EN: raise halt_R14H for 3 cycles on sample (1024,0) of test 1 -> sample_R14S holds (1024,0) for 4 cycles, then continues with (2048,0); 6 distinct samples total.
